// File: rtl/cva6_unc_wr_arb.sv
// rtl/cva6_unc_wr_arb.sv - round-robin arbiter funnelling per-core uncached stores onto one AXI write port
// Optional feature macro: CVA6_UNC_WR_ARB_PERF_EN adds per-core stall counters on stall_cnt_o.
module cva6_unc_wr_arb #(
    parameter int NUM_CORES = 2,
    parameter int ID_W      = 4,
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int MAX_OUT   = 7,
    localparam int STRB_W   = DATA_W / 8,
    localparam int CORE_W   = $clog2(NUM_CORES)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NUM_CORES-1:0]        req_valid_i,
    output logic [NUM_CORES-1:0]        req_ready_o,
    input  logic [NUM_CORES*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_CORES*DATA_W-1:0] req_data_i,
    input  logic [NUM_CORES*STRB_W-1:0] req_strb_i,
    input  logic [NUM_CORES*ID_W-1:0]   req_id_i,
    output logic                        aw_valid_o,
    input  logic                        aw_ready_i,
    output logic [ADDR_W-1:0]           aw_addr_o,
    output logic [ID_W+CORE_W-1:0]      aw_id_o,
    output logic                        w_valid_o,
    input  logic                        w_ready_i,
    output logic [DATA_W-1:0]           w_data_o,
    output logic [STRB_W-1:0]           w_strb_o,
    output logic                        w_last_o,
    input  logic                        b_valid_i,
    output logic                        b_ready_o,
    input  logic [ID_W+CORE_W-1:0]      b_id_i,
    input  logic [1:0]                  b_resp_i,
    output logic [NUM_CORES-1:0]        rsp_valid_o,
    input  logic [NUM_CORES-1:0]        rsp_ready_i,
    output logic [ID_W-1:0]             rsp_id_o,
    output logic [1:0]                  rsp_resp_o,
`ifdef CVA6_UNC_WR_ARB_PERF_EN
    output logic [NUM_CORES*32-1:0]     stall_cnt_o,
`endif
    output logic                        bad_id_o
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

    state_e              state_q, state_d;
    logic [CORE_W-1:0]   rr_q, rr_d, core_q, grant_core;
    logic                grant_found, grant;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [STRB_W-1:0]   strb_q;
    logic [ID_W-1:0]     id_q;
    logic                aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic                aw_hs, w_hs;
    logic [CNT_W-1:0]    cnt_q [NUM_CORES];
    logic [NUM_CORES-1:0] eligible, inc, dec;
    logic [CORE_W-1:0]   b_core;
    logic                b_bad, bad_q;

    always_comb begin
        for (int k = 0; k < NUM_CORES; k++) begin
            eligible[k] = req_valid_i[k] && (cnt_q[k] < CNT_W'(MAX_OUT));
        end
    end

    // Search starts at rr_q, which always holds the core after the last grant.
    always_comb begin
        grant_found = 1'b0;
        grant_core  = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            int idx;
            idx = int'(rr_q) + i;
            if (idx >= NUM_CORES) idx = idx - NUM_CORES;
            if (!grant_found && eligible[idx]) begin
                grant_found = 1'b1;
                grant_core  = CORE_W'(idx);
            end
        end
    end

    assign grant = (state_q == IDLE) && grant_found;
    assign rr_d  = (int'(grant_core) == NUM_CORES - 1) ? '0 : grant_core + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_found) state_d = SEND;
            SEND:    if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = '0;
        aw_valid_o  = 1'b0;
        w_valid_o   = 1'b0;
        if (rst_ni) begin
            if (grant) req_ready_o[grant_core] = 1'b1;
            if (state_q == SEND) begin
                aw_valid_o = !aw_done_q;
                w_valid_o  = !w_done_q;
            end
        end
    end

    assign aw_hs     = aw_valid_o && aw_ready_i;
    assign w_hs      = w_valid_o && w_ready_i;
    assign aw_done_d = grant ? 1'b0 : (aw_done_q || aw_hs);
    assign w_done_d  = grant ? 1'b0 : (w_done_q || w_hs);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q      <= '0;
            core_q    <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
            id_q      <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            if (grant) begin
                rr_q   <= rr_d;
                core_q <= grant_core;
                addr_q <= req_addr_i[grant_core*ADDR_W +: ADDR_W];
                data_q <= req_data_i[grant_core*DATA_W +: DATA_W];
                strb_q <= req_strb_i[grant_core*STRB_W +: STRB_W];
                id_q   <= req_id_i[grant_core*ID_W +: ID_W];
            end
        end
    end

    assign aw_addr_o = addr_q;
    assign aw_id_o   = {core_q, id_q};
    assign w_data_o  = data_q;
    assign w_strb_o  = strb_q;
    assign w_last_o  = 1'b1;

    // B responses whose core field names no real core are swallowed and flagged.
    assign b_core     = b_id_i[ID_W+CORE_W-1:ID_W];
    assign b_bad      = ({1'b0, b_core} >= (CORE_W+1)'(NUM_CORES));
    assign rsp_id_o   = b_id_i[ID_W-1:0];
    assign rsp_resp_o = b_resp_i;

    always_comb begin
        rsp_valid_o = '0;
        b_ready_o   = 1'b0;
        dec         = '0;
        inc         = '0;
        if (rst_ni) begin
            b_ready_o = b_bad;
            for (int k = 0; k < NUM_CORES; k++) begin
                inc[k] = grant && (grant_core == CORE_W'(k));
                if (!b_bad && (b_core == CORE_W'(k))) begin
                    rsp_valid_o[k] = b_valid_i;
                    b_ready_o      = rsp_ready_i[k];
                    dec[k]         = b_valid_i && rsp_ready_i[k] && (cnt_q[k] != '0);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM_CORES; k++) cnt_q[k] <= '0;
            bad_q <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_CORES; k++) begin
                if (inc[k] && !dec[k] && (cnt_q[k] != CNT_W'(MAX_OUT)))
                    cnt_q[k] <= cnt_q[k] + 1'b1;
                else if (dec[k] && !inc[k])
                    cnt_q[k] <= cnt_q[k] - 1'b1;
            end
            if (b_valid_i && b_bad) bad_q <= 1'b1;
        end
    end

    assign bad_id_o = bad_q;

`ifdef CVA6_UNC_WR_ARB_PERF_EN
    logic [31:0] stall_q [NUM_CORES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM_CORES; k++) stall_q[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_CORES; k++) begin
                if (req_valid_i[k] && (cnt_q[k] == CNT_W'(MAX_OUT)) && (stall_q[k] != '1))
                    stall_q[k] <= stall_q[k] + 32'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_stall
        assign stall_cnt_o[g*32 +: 32] = stall_q[g];
    end
`endif

endmodule

// File: tb/tb_cva6_unc_wr_arb.sv
// tb/tb_cva6_unc_wr_arb.sv - directed self-checking bench for cva6_unc_wr_arb
module tb_cva6_unc_wr_arb;
    localparam int NC = 3;
    localparam int IW = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int CW = 2;

    logic            clk, rst_n;
    logic [NC-1:0]   req_valid, req_ready;
    logic [NC*AW-1:0] req_addr;
    logic [NC*DW-1:0] req_data;
    logic [NC*SW-1:0] req_strb;
    logic [NC*IW-1:0] req_id;
    logic            aw_valid, aw_ready, w_valid, w_ready, w_last;
    logic [AW-1:0]   aw_addr;
    logic [IW+CW-1:0] aw_id, b_id;
    logic [DW-1:0]   w_data;
    logic [SW-1:0]   w_strb;
    logic            b_valid, b_ready, bad_id;
    logic [1:0]      b_resp, rsp_resp;
    logic [NC-1:0]   rsp_valid, rsp_ready;
    logic [IW-1:0]   rsp_id;

    typedef struct {
        logic [IW+CW-1:0] id;
        logic [AW-1:0]    addr;
        logic [DW-1:0]    data;
        logic [SW-1:0]    strb;
    } exp_t;
    exp_t sb[$];

    int n_chk  = 0;
    int n_fail = 0;

    cva6_unc_wr_arb #(.NUM_CORES(NC), .ID_W(IW), .ADDR_W(AW), .DATA_W(DW), .MAX_OUT(7)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_data_i(req_data), .req_strb_i(req_strb), .req_id_i(req_id),
        .aw_valid_o(aw_valid), .aw_ready_i(aw_ready), .aw_addr_o(aw_addr), .aw_id_o(aw_id),
        .w_valid_o(w_valid), .w_ready_i(w_ready), .w_data_o(w_data), .w_strb_o(w_strb), .w_last_o(w_last),
        .b_valid_i(b_valid), .b_ready_o(b_ready), .b_id_i(b_id), .b_resp_i(b_resp),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id), .rsp_resp_o(rsp_resp),
        .bad_id_o(bad_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req_valid = '0; b_valid = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // Expects core k granted now, then its write on AW/W next cycle with both readies high.
    task automatic grant_send(input int k);
        exp_t e;
        chk("grant", 64'(req_ready), 64'(3'b001 << k));
        e.id   = {2'(k), req_id[k*IW +: IW]};
        e.addr = req_addr[k*AW +: AW];
        e.data = req_data[k*DW +: DW];
        e.strb = req_strb[k*SW +: SW];
        sb.push_back(e);
        nxt();
        e = sb.pop_front();
        chk("aw_valid", 64'(aw_valid), 64'(1));
        chk("w_valid", 64'(w_valid), 64'(1));
        chk("aw_addr", 64'(aw_addr), 64'(e.addr));
        chk("aw_id", 64'(aw_id), 64'(e.id));
        chk("w_data", 64'(w_data), 64'(e.data));
        chk("w_strb", 64'(w_strb), 64'(e.strb));
        chk("w_last", 64'(w_last), 64'(1));
        nxt();
    endtask

    task automatic count_grants(input int core, input int cycles, input int expected, input string tag);
        int ng;
        ng = 0;
        for (int i = 0; i < cycles; i++) begin
            if (req_ready[core]) ng++;
            nxt();
        end
        chk(tag, 64'(ng), 64'(expected));
    endtask

    initial begin
        for (int k = 0; k < NC; k++) begin
            req_addr[k*AW +: AW] = 32'hA000_0000 | (32'(k) << 8);
            req_data[k*DW +: DW] = 32'hD000_0000 + 32'(k) * 32'h11;
            req_strb[k*SW +: SW] = 4'(1 << k) | 4'h8;
            req_id[k*IW +: IW]   = 4'(k + 3);
        end
        rst_n = 1'b0; req_valid = '0; aw_ready = 1'b0; w_ready = 1'b0;
        b_valid = 1'b0; b_id = '0; b_resp = '0; rsp_ready = '0;
        repeat (2) @(negedge clk);

        // Outputs held low during reset even with live inputs
        req_valid = 3'b111; b_valid = 1'b1; b_id = {2'd0, 4'h1}; rsp_ready = 3'b111;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_aw_valid", 64'(aw_valid), 64'(0));
        chk("rst_w_valid", 64'(w_valid), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_b_ready", 64'(b_ready), 64'(0));
        chk("rst_bad_id", 64'(bad_id), 64'(0));
        @(negedge clk);
        req_valid = '0; b_valid = 1'b0; rsp_ready = '0; rst_n = 1'b1;
        #1;

        // Round-robin alternation, then three-way rotation from the core after the last grant
        req_valid = 3'b011; aw_ready = 1'b1; w_ready = 1'b1;
        #1;
        grant_send(0); grant_send(1); grant_send(0); grant_send(1);
        req_valid = 3'b111;
        #1;
        grant_send(2); grant_send(0); grant_send(1);

        // Outstanding limit of 7, released by one B
        do_reset();
        req_valid = 3'b001;
        #1;
        for (int g = 0; g < 7; g++) grant_send(0);
        for (int i = 0; i < 3; i++) begin
            chk("limit_no_grant", 64'(req_ready), 64'(0));
            chk("limit_no_aw", 64'(aw_valid), 64'(0));
            nxt();
        end
        b_valid = 1'b1; b_id = {2'd0, 4'h9}; b_resp = 2'b10; rsp_ready = 3'b000;
        #1;
        chk("b_ready_bp", 64'(b_ready), 64'(0));
        chk("rsp_valid_c0", 64'(rsp_valid), 64'(3'b001));
        nxt();
        chk("limit_bp_no_grant", 64'(req_ready), 64'(0));
        rsp_ready = 3'b001;
        #1;
        chk("b_ready_c0", 64'(b_ready), 64'(1));
        chk("rsp_id", 64'(rsp_id), 64'(4'h9));
        chk("rsp_resp", 64'(rsp_resp), 64'(2'b10));
        chk("same_cycle_no_grant", 64'(req_ready), 64'(0));
        nxt();
        b_valid = 1'b0;
        #1;
        grant_send(0);

        // AW accepted at once, W stalled three cycles
        do_reset();
        req_valid = 3'b100; aw_ready = 1'b1; w_ready = 1'b0;
        #1;
        chk("split_grant", 64'(req_ready), 64'(3'b100));
        nxt();
        req_valid = '0;
        #1;
        chk("split_c1_aw", 64'(aw_valid), 64'(1));
        chk("split_c1_w", 64'(w_valid), 64'(1));
        nxt();
        chk("split_c2_aw", 64'(aw_valid), 64'(0));
        chk("split_c2_w", 64'(w_valid), 64'(1));
        nxt();
        chk("split_c3_aw", 64'(aw_valid), 64'(0));
        chk("split_c3_w", 64'(w_valid), 64'(1));
        nxt();
        w_ready = 1'b1; req_valid = 3'b100;
        #1;
        chk("split_c4_w", 64'(w_valid), 64'(1));
        chk("split_c4_no_grant", 64'(req_ready), 64'(0));
        nxt();
        chk("split_idle_grant", 64'(req_ready), 64'(3'b100));
        chk("split_idle_w", 64'(w_valid), 64'(0));
        req_valid = '0;
        #1;
        nxt(); nxt();

        // Grant and B for core 1 in the same cycle leave its count at 3
        do_reset();
        req_valid = 3'b010; aw_ready = 1'b1; w_ready = 1'b1;
        #1;
        grant_send(1); grant_send(1); grant_send(1);
        b_valid = 1'b1; b_id = {2'd1, 4'h2}; b_resp = 2'b00; rsp_ready = 3'b010;
        #1;
        chk("coinc_grant", 64'(req_ready), 64'(3'b010));
        chk("coinc_rsp_valid", 64'(rsp_valid), 64'(3'b010));
        chk("coinc_b_ready", 64'(b_ready), 64'(1));
        nxt();
        b_valid = 1'b0;
        #1;
        count_grants(1, 20, 4, "coinc_remaining_grants");

        // Out-of-range core field in B
        b_valid = 1'b1; b_id = {2'd3, 4'h7}; rsp_ready = 3'b000;
        #1;
        chk("bad_b_ready", 64'(b_ready), 64'(1));
        chk("bad_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("bad_flag_before", 64'(bad_id), 64'(0));
        nxt();
        b_valid = 1'b0;
        #1;
        chk("bad_flag_set", 64'(bad_id), 64'(1));
        chk("bad_no_cnt_change", 64'(req_ready), 64'(0));
        nxt(); nxt(); nxt();
        chk("bad_flag_sticky", 64'(bad_id), 64'(1));

        // Reset in the middle of SEND
        do_reset();
        chk("bad_flag_cleared", 64'(bad_id), 64'(0));
        req_valid = 3'b001; aw_ready = 1'b1; w_ready = 1'b1;
        #1;
        grant_send(0); grant_send(0);
        aw_ready = 1'b0; w_ready = 1'b0;
        #1;
        chk("midsend_grant", 64'(req_ready), 64'(3'b001));
        nxt();
        chk("midsend_aw_valid", 64'(aw_valid), 64'(1));
        rst_n = 1'b0; b_valid = 1'b1; b_id = {2'd0, 4'h1}; rsp_ready = 3'b111;
        #1;
        chk("async_aw_valid", 64'(aw_valid), 64'(0));
        chk("async_w_valid", 64'(w_valid), 64'(0));
        chk("async_req_ready", 64'(req_ready), 64'(0));
        chk("async_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("async_b_ready", 64'(b_ready), 64'(0));
        @(negedge clk);
        b_valid = 1'b0; req_valid = '0; rst_n = 1'b1; aw_ready = 1'b1; w_ready = 1'b1;
        #1;
        chk("post_rst_aw", 64'(aw_valid), 64'(0));
        nxt();
        chk("no_replay_aw", 64'(aw_valid), 64'(0));
        chk("no_replay_w", 64'(w_valid), 64'(0));
        req_valid = 3'b001;
        #1;
        count_grants(0, 20, 7, "post_rst_grants");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
